// File: rtl/gal_olmc_bank.sv
// gal_olmc_bank: behavioural model of a bank of GAL output logic macrocells (OLMCs).
//
// Each channel ORs DEPTH product terms taken over the shared input bus A. A second single
// product gates the output enable. The SOP result either drives the pin directly
// (combinational) or through a D flop (registered), with optional output inversion.
//
// Product-term encoding (2 bits per input, input i at bits [2*i +: 2] of a product):
//   00 = input unused, 01 = A[i] must be 0, 10 = A[i] must be 1, 11 = product forced 0.
// TABLE holds product p of channel c at bits [(c*DEPTH+p)*2*WIDTH +: 2*WIDTH].
// OE_TABLE holds the enable product of channel c at bits [c*2*WIDTH +: 2*WIDTH].
//
// Optional feature: define GAL_OLMC_SP_EN to add the synchronous-preset input SP.
// Registered channels then load 1 on an edge with SP=1. Priority is rst > SP > sop.
//
// Ports:
//   clk   in   1         bank clock, rising edge
//   rst   in   1         synchronous active-high reset (registered channels only)
//   SP    in   1         synchronous preset term (only with GAL_OLMC_SP_EN)
//   A     in   WIDTH     shared product-term inputs
//   Y     out  CHANNELS  pin value per channel
//   Y_OE  out  CHANNELS  output enable per channel (1 = driven)
//   FB    out  CHANNELS  feedback per channel
module gal_olmc_bank #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4,
  // Left untyped so that the width a user supplies can be checked against the geometry.
  parameter TABLE                 = {(CHANNELS * DEPTH * 2 * WIDTH){1'b0}},
  parameter OE_TABLE              = {(CHANNELS * WIDTH){2'b10}},
  parameter logic [CHANNELS-1:0] REG_MASK = '0,
  parameter logic [CHANNELS-1:0] INV_MASK = '0
) (
  input  logic                clk,
  input  logic                rst,
`ifdef GAL_OLMC_SP_EN
  input  logic                SP,
`endif
  input  logic [WIDTH-1:0]    A,
  output logic [CHANNELS-1:0] Y,
  output logic [CHANNELS-1:0] Y_OE,
  output logic [CHANNELS-1:0] FB
);

  // Elaboration-time sanity checks on the configuration.
  if (CHANNELS == 0 || WIDTH == 0 || DEPTH == 0) begin : g_bad_size
    $error("gal_olmc_bank: CHANNELS, WIDTH and DEPTH must be non-zero");
  end
  if ($bits(TABLE) != CHANNELS * DEPTH * 2 * WIDTH) begin : g_bad_table
    $error("gal_olmc_bank: TABLE width must be CHANNELS*DEPTH*2*WIDTH");
  end
  if ($bits(OE_TABLE) != CHANNELS * 2 * WIDTH) begin : g_bad_oe_table
    $error("gal_olmc_bank: OE_TABLE width must be CHANNELS*2*WIDTH");
  end

  // Unused fields never read A[i], so an unknown on an unused input cannot leak into the
  // product. A forced-off field clears the product outright, overriding unknowns on
  // other inputs.
  function automatic logic eval_prod(input logic [2*WIDTH-1:0] fld,
                                     input logic [WIDTH-1:0]   a);
    logic r;
    r = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      case (fld[2*i +: 2])
        2'b01:   r = r & ~a[i];
        2'b10:   r = r & a[i];
        2'b11:   r = 1'b0;
        default: ;
      endcase
    end
    return r;
  endfunction

  logic [CHANNELS-1:0] w_sop;
  logic [CHANNELS-1:0] w_oe;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [DEPTH-1:0] w_prod;

    for (genvar p = 0; p < DEPTH; p++) begin : g_prod
      assign w_prod[p] = eval_prod(TABLE[(c * DEPTH + p) * 2 * WIDTH +: 2 * WIDTH], A);
    end

    assign w_sop[c] = |w_prod;
    assign w_oe[c]  = eval_prod(OE_TABLE[c * 2 * WIDTH +: 2 * WIDTH], A);

    if (REG_MASK[c]) begin : g_reg
      logic r_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_q <= 1'b0;
`ifdef GAL_OLMC_SP_EN
        end else if (SP) begin
          r_q <= 1'b1;
`endif
        end else begin
          r_q <= w_sop[c];
        end
      end

      assign Y[c]  = r_q ^ INV_MASK[c];
      // Registered feedback comes from the flop, not the pin, so it ignores OE and inversion.
      assign FB[c] = r_q;
    end else begin : g_comb
      logic w_y;

      assign w_y   = w_sop[c] ^ INV_MASK[c];
      assign Y[c]  = w_y;
      // A disabled pin floats; its feedback is modelled as 0.
      assign FB[c] = w_oe[c] & w_y;
    end
  end

  assign Y_OE = w_oe;

  // clk/rst (and SP) go unread when no channel is registered.
  logic w_unused;
`ifdef GAL_OLMC_SP_EN
  assign w_unused = &{1'b0, clk, rst, SP};
`else
  assign w_unused = &{1'b0, clk, rst};
`endif

endmodule

// File: tb/tb_gal_olmc_bank.sv
// Bench for gal_olmc_bank. Four channels: combinational, combinational inverted,
// registered, and registered inverted. The product terms are described as "must-be-1"
// and "must-be-0" masks plus a kill flag. The DUT tables are encoded from these masks,
// and the reference model evaluates the masks directly with plain arithmetic.
module tb_gal_olmc_bank;

  localparam int unsigned CH = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned D  = 3;

  localparam logic [CH-1:0] REG = 4'b1100;
  localparam logic [CH-1:0] INV = 4'b1010;

  // Product index = channel*D + product.
  localparam logic [7:0] M1 [12] = '{8'h03, 8'h10, 8'h00,  8'h81, 8'h00, 8'h08,
                                     8'h01, 8'h06, 8'h00,  8'h00, 8'h60, 8'h08};
  localparam logic [7:0] M0 [12] = '{8'h04, 8'h20, 8'h00,  8'h00, 8'h42, 8'h08,
                                     8'h00, 8'h80, 8'h00,  8'h11, 8'h00, 8'h01};
  localparam logic [11:0] KILL = 12'h104;  // products 2 and 8 carry a forced-off field

  // Enable products: ch0 = ~A7, ch1 = always, ch2 = A1, ch3 = A6 & ~A5.
  localparam logic [7:0] OM1 [4] = '{8'h00, 8'h00, 8'h02, 8'h40};
  localparam logic [7:0] OM0 [4] = '{8'h80, 8'h00, 8'h00, 8'h20};

`ifdef GAL_OLMC_SP_EN
  localparam bit SP_ON = 1'b1;
`else
  localparam bit SP_ON = 1'b0;
`endif

  function automatic logic [15:0] enc(input logic [7:0] m1, input logic [7:0] m0,
                                      input logic k);
    logic [15:0] f;
    for (int i = 0; i < 8; i++) f[2*i +: 2] = k ? 2'b11 : {m1[i], m0[i]};
    return f;
  endfunction

  localparam logic [CH*D*2*W-1:0] TBL = {
    enc(M1[11], M0[11], KILL[11]), enc(M1[10], M0[10], KILL[10]), enc(M1[9], M0[9], KILL[9]),
    enc(M1[8], M0[8], KILL[8]),    enc(M1[7], M0[7], KILL[7]),    enc(M1[6], M0[6], KILL[6]),
    enc(M1[5], M0[5], KILL[5]),    enc(M1[4], M0[4], KILL[4]),    enc(M1[3], M0[3], KILL[3]),
    enc(M1[2], M0[2], KILL[2]),    enc(M1[1], M0[1], KILL[1]),    enc(M1[0], M0[0], KILL[0])};
  localparam logic [CH*2*W-1:0] OE_TBL = {
    enc(OM1[3], OM0[3], 1'b0), enc(OM1[2], OM0[2], 1'b0),
    enc(OM1[1], OM0[1], 1'b0), enc(OM1[0], OM0[0], 1'b0)};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sp  = 1'b0;
  logic [W-1:0]  a   = '0;
  logic [CH-1:0] y, y_oe, fb;

  always #10 clk = ~clk;

  gal_olmc_bank #(
    .CHANNELS (CH),
    .WIDTH    (W),
    .DEPTH    (D),
    .TABLE    (TBL),
    .OE_TABLE (OE_TBL),
    .REG_MASK (REG),
    .INV_MASK (INV)
  ) dut (
    .clk  (clk),
    .rst  (rst),
`ifdef GAL_OLMC_SP_EN
    .SP   (sp),
`endif
    .A    (a),
    .Y    (y),
    .Y_OE (y_oe),
    .FB   (fb)
  );

  // ---------------- reference model ----------------
  function automatic logic sop_m(input int c, input logic [7:0] av);
    for (int p = 0; p < int'(D); p++) begin
      int idx;
      idx = c * int'(D) + p;
      if (!KILL[idx] && ((av & M1[idx]) == M1[idx]) && ((av & M0[idx]) == 8'h00)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic oe_m(input int c, input logic [7:0] av);
    return ((av & OM1[c]) == OM1[c]) && ((av & OM0[c]) == 8'h00);
  endfunction

  // Expected {Y, Y_OE, FB} for inputs av with registered state qv.
  function automatic logic [3*CH-1:0] expect_out(input logic [7:0] av, input logic [CH-1:0] qv);
    logic [CH-1:0] ey, eo, ef;
    for (int c = 0; c < int'(CH); c++) begin
      eo[c] = oe_m(c, av);
      if (REG[c]) begin
        ey[c] = qv[c] ^ INV[c];
        ef[c] = qv[c];
      end else begin
        ey[c] = sop_m(c, av) ^ INV[c];
        ef[c] = eo[c] ? ey[c] : 1'b0;
      end
    end
    return {ey, eo, ef};
  endfunction

  // ---------------- scoreboard ----------------
  logic [3*CH-1:0] exp_q [$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check_one();
    logic [3*CH-1:0] e, g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {y, y_oe, fb};
      n_vec++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL olmc_out t=%0t A=%h: got Y=%b OE=%b FB=%b, want Y=%b OE=%b FB=%b",
                 $time, a, g[11:8], g[7:4], g[3:0], e[11:8], e[7:4], e[3:0]);
      end
    end
  endtask

  // Monitor: samples twice per cycle while clk is low, i.e. away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #2 check_one();
      #4 check_one();
    end
  end

  // Stimulus: each cycle drives A twice (the second value is the one the flops capture),
  // so registered outputs are also checked for stability while A moves mid-cycle.
  initial begin
    logic [CH-1:0] q_m;
    q_m = '0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst = (n < 3) || ($urandom_range(7) == 0);
      sp  = ($urandom_range(5) == 0);
      a   = 8'($urandom);
      exp_q.push_back(expect_out(a, q_m));
      #4;
      a   = 8'($urandom);
      exp_q.push_back(expect_out(a, q_m));
      for (int c = 0; c < int'(CH); c++) begin
        if (rst)                q_m[c] = 1'b0;
        else if (SP_ON && sp)   q_m[c] = 1'b1;
        else                    q_m[c] = sop_m(c, a);
      end
    end
    @(negedge clk);
    #8;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
